// File: rtl/ovl_fire_collector.sv
`timescale 1ns/1ps
// Collects OVL checker fire buses into per-checker saturating failure counters,
// captures the first failure with its timestamp, and runs a 4-phase clear handshake.
module ovl_fire_collector #(
    parameter int NUM_CHECKERS = 4,
    parameter int CNT_WIDTH    = 8,
    parameter int TS_WIDTH     = 16,
    localparam int SEL_W       = (NUM_CHECKERS > 1) ? $clog2(NUM_CHECKERS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [3*NUM_CHECKERS-1:0] fire,
    input  logic                      clr_req,
    output logic                      clr_ack,
    input  logic [SEL_W-1:0]          rd_sel,
    output logic [CNT_WIDTH-1:0]      rd_count,
    output logic                      first_valid,
    output logic [SEL_W-1:0]          first_id,
    output logic [TS_WIDTH-1:0]       first_time,
    output logic                      irq
);

    typedef enum logic [1:0] {RUN, CLR, WAIT_DROP} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_WIDTH-1:0]    cnt_p1 [NUM_CHECKERS];
    logic [TS_WIDTH-1:0]     ts_p1;
    logic [NUM_CHECKERS-1:0] fail_p0;
    logic [SEL_W-1:0]        fail_id_p0;

    function automatic logic [CNT_WIDTH-1:0] sat_cnt(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    function automatic logic [TS_WIDTH-1:0] sat_ts(input logic [TS_WIDTH-1:0] v);
        return (&v) ? v : v + TS_WIDTH'(1);
    endfunction

    always_comb begin
        state_nxt = state;
        clr_ack   = 1'b0;
        case (state)
            RUN: begin
                if (clr_req) state_nxt = CLR;
            end
            CLR: begin
                clr_ack   = 1'b1;
                state_nxt = WAIT_DROP;
            end
            WAIT_DROP: begin
                clr_ack = 1'b1;
                if (!clr_req) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // p0: per-checker failure decode; cover bit masked out, lowest index wins
    always_comb begin
        fail_p0    = '0;
        fail_id_p0 = '0;
        for (int i = NUM_CHECKERS - 1; i >= 0; i--) begin
            fail_p0[i] = enable & (|(fire[3*i +: 3] & 3'b011));
            if (fail_p0[i]) fail_id_p0 = SEL_W'(i);
        end
    end

    // p1: registered counters, timestamp and first-failure capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            ts_p1       <= '0;
            first_valid <= 1'b0;
            first_id    <= '0;
            first_time  <= '0;
            irq         <= 1'b0;
            for (int i = 0; i < NUM_CHECKERS; i++) cnt_p1[i] <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLR) begin
                ts_p1       <= '0;
                first_valid <= 1'b0;
                first_id    <= '0;
                first_time  <= '0;
                irq         <= 1'b0;
                for (int i = 0; i < NUM_CHECKERS; i++) cnt_p1[i] <= '0;
            end else begin
                if (enable) ts_p1 <= sat_ts(ts_p1);
                for (int i = 0; i < NUM_CHECKERS; i++) begin
                    if (fail_p0[i]) cnt_p1[i] <= sat_cnt(cnt_p1[i]);
                end
                if (!first_valid && (|fail_p0)) begin
                    first_valid <= 1'b1;
                    irq         <= 1'b1;
                    first_id    <= fail_id_p0;
                    first_time  <= ts_p1;
                end
            end
        end
    end

    // Out-of-range selects fall through to zero
    always_comb begin
        rd_count = '0;
        for (int i = 0; i < NUM_CHECKERS; i++) begin
            if (rd_sel == SEL_W'(i)) rd_count = cnt_p1[i];
        end
    end

endmodule

// File: tb/tb_ovl_fire_collector.sv
`timescale 1ns/1ps
// Bench for ovl_fire_collector: directed scenarios plus random traffic, two instances
// (4 checkers/16-bit timestamp and 3 checkers/4-bit timestamp) against one reference model.
module tb_ovl_fire_collector;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        clr_req = 1'b0;
    logic [11:0] fire = '0;
    logic [1:0]  rd_sel = '0;

    logic        clr_ack_a, fv_a, irq_a;
    logic [1:0]  fid_a;
    logic [15:0] ft_a;
    logic [7:0]  cnt_a;
    logic        clr_ack_b, fv_b, irq_b;
    logic [1:0]  fid_b;
    logic [3:0]  ft_b;
    logic [7:0]  cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    ovl_fire_collector #(.NUM_CHECKERS(4), .CNT_WIDTH(8), .TS_WIDTH(16)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .fire(fire),
        .clr_req(clr_req), .clr_ack(clr_ack_a), .rd_sel(rd_sel), .rd_count(cnt_a),
        .first_valid(fv_a), .first_id(fid_a), .first_time(ft_a), .irq(irq_a)
    );

    ovl_fire_collector #(.NUM_CHECKERS(3), .CNT_WIDTH(8), .TS_WIDTH(4)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .fire(fire[8:0]),
        .clr_req(clr_req), .clr_ack(clr_ack_b), .rd_sel(rd_sel), .rd_count(cnt_b),
        .first_valid(fv_b), .first_id(fid_b), .first_time(ft_b), .irq(irq_b)
    );

    // Reference model: index 0 describes instance A, index 1 instance B
    int m_cnt [4];
    int m_ts  [2];
    bit m_fv  [2];
    int m_fid [2];
    int m_ft  [2];
    int m_phase;  // 0 idle, 1 clearing this cycle, 2 waiting for request to drop

    function automatic int nch(input int v);
        return (v == 0) ? 4 : 3;
    endfunction

    function automatic int tsmax(input int v);
        return (v == 0) ? 65535 : 15;
    endfunction

    task automatic model_zero();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        for (int v = 0; v < 2; v++) begin
            m_ts[v] = 0; m_fv[v] = 0; m_fid[v] = 0; m_ft[v] = 0;
        end
    endtask

    task automatic model_update();
        bit f [4];
        bit found;
        for (int i = 0; i < 4; i++) f[i] = enable && (fire[3*i] || fire[3*i+1]);
        if (m_phase == 1) begin
            model_zero();
            m_phase = 2;
        end else begin
            for (int v = 0; v < 2; v++) begin
                found = 0;
                if (!m_fv[v]) begin
                    for (int i = 0; i < nch(v); i++) begin
                        if (f[i] && !found) begin
                            found = 1; m_fv[v] = 1; m_fid[v] = i; m_ft[v] = m_ts[v];
                        end
                    end
                end
            end
            for (int i = 0; i < 4; i++) if (f[i] && m_cnt[i] < 255) m_cnt[i]++;
            for (int v = 0; v < 2; v++) if (enable && m_ts[v] < tsmax(v)) m_ts[v]++;
            if (m_phase == 0 && clr_req) m_phase = 1;
            else if (m_phase == 2 && !clr_req) m_phase = 0;
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("fv_a", 32'(fv_a), 32'(m_fv[0]));
        check_val("irq_a", 32'(irq_a), 32'(m_fv[0]));
        check_val("fid_a", 32'(fid_a), m_fv[0] ? m_fid[0] : 0);
        check_val("ft_a", 32'(ft_a), m_fv[0] ? m_ft[0] : 0);
        check_val("ack_a", 32'(clr_ack_a), 32'(m_phase != 0));
        check_val("fv_b", 32'(fv_b), 32'(m_fv[1]));
        check_val("irq_b", 32'(irq_b), 32'(m_fv[1]));
        check_val("fid_b", 32'(fid_b), m_fv[1] ? m_fid[1] : 0);
        check_val("ft_b", 32'(ft_b), m_fv[1] ? m_ft[1] : 0);
        check_val("ack_b", 32'(clr_ack_b), 32'(m_phase != 0));
        for (int i = 0; i < 4; i++) begin
            rd_sel = 2'(i);
            #1;
            check_val($sformatf("cnt_a[%0d]", i), 32'(cnt_a), m_cnt[i]);
            check_val($sformatf("cnt_b[%0d]", i), 32'(cnt_b), (i < 3) ? m_cnt[i] : 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_clear();
        enable = 0; fire = '0; clr_req = 1;
        step(); step();
        clr_req = 0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        m_phase = 0;
        model_zero();
        repeat (2) @(negedge clk);
        reset_n = 1;
        check_all();

        // Disabled collection: nothing counts, timestamp holds
        enable = 0; fire = 12'hfff;
        repeat (10) step();
        check_val("dis_fv", 32'(fv_a), 0);

        // First capture at timestamp 5, checkers 0 and 2
        enable = 1; fire = '0;
        repeat (5) step();
        fire = 12'h081;
        step();
        check_val("first_fv", 32'(fv_a), 1);
        check_val("first_id", 32'(fid_a), 0);
        check_val("first_time", 32'(ft_a), 5);
        check_val("first_irq", 32'(irq_a), 1);
        rd_sel = 0; #1 check_val("first_cnt0", 32'(cnt_a), 1);
        rd_sel = 2; #1 check_val("first_cnt2", 32'(cnt_a), 1);
        fire = '0;

        // Clear with checker 3 failing during the clearing cycle
        enable = 1; clr_req = 1;
        step();
        check_val("clr_ack_clr", 32'(clr_ack_a), 1);
        fire = 12'h200;
        step();
        check_val("clr_ack_wait", 32'(clr_ack_a), 1);
        check_val("clr_fv", 32'(fv_a), 0);
        check_val("clr_ft", 32'(ft_a), 0);
        check_val("clr_cnt3", 32'(cnt_a), 0);
        fire = '0; clr_req = 0;
        step();
        check_val("clr_ack_drop", 32'(clr_ack_a), 0);

        // Cover-only bits ignored, then counter saturation on xcheck
        do_clear();
        enable = 1; fire = 12'h020;
        repeat (5) step();
        check_val("cover_fv", 32'(fv_a), 0);
        rd_sel = 1; #1 check_val("cover_cnt1", 32'(cnt_a), 0);
        fire = 12'h010;
        repeat (300) step();
        rd_sel = 1; #1 check_val("sat_cnt1", 32'(cnt_a), 255);
        check_val("sat_cnt1_b", 32'(cnt_b), 255);

        // Timestamp saturation on the 4-bit instance
        do_clear();
        enable = 1; fire = '0;
        repeat (20) step();
        fire = 12'h001;
        step();
        check_val("ts_sat_b", 32'(ft_b), 15);
        check_val("ts_a", 32'(ft_a), 20);
        check_val("ts_fid_b", 32'(fid_b), 0);
        fire = '0;

        // Reset in the middle of the wait-for-drop phase
        clr_req = 1;
        step(); step();
        fire = 12'h040;
        repeat (3) step();
        fire = '0;
        rd_sel = 2; #1 check_val("pre_rst_cnt2", 32'(cnt_a), 3);
        reset_n = 0;
        #1;
        check_val("rst_fv", 32'(fv_a), 0);
        check_val("rst_irq", 32'(irq_a), 0);
        check_val("rst_ack", 32'(clr_ack_a), 0);
        check_val("rst_ft", 32'(ft_a), 0);
        check_val("rst_cnt2", 32'(cnt_a), 0);
        @(negedge clk);
        m_phase = 0;
        model_zero();
        reset_n = 1;
        check_all();
        step();
        check_val("rst_new_clear", 32'(clr_ack_a), 1);
        clr_req = 0;
        step(); step();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            enable = ($urandom_range(0, 9) < 8);
            for (int b = 0; b < 12; b++) fire[b] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) clr_req = ~clr_req;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ovl_fire_collector.md
OVL_FIRE_COLLECTOR -- requirements
Module: ovl_fire_collector

Interface
REQ-001 SHALL have parameter NUM_CHECKERS, default 4: number of checker fire buses collected (1..16).
REQ-002 SHALL have parameter CNT_WIDTH, default 8: width of each per-checker failure counter.
REQ-003 SHALL have parameter TS_WIDTH, default 16: width of the cycle timestamp.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port enable  input  1  high = collect fires and advance the timestamp.
REQ-007 SHALL have port fire  input  3*NUM_CHECKERS  OVL fire buses; checker i owns bits [3i+2:3i] = {cover, xcheck, 2state}.
REQ-008 SHALL have port clr_req  input  1  clear request (level, 4-phase).
REQ-009 SHALL have port clr_ack  output  1  clear acknowledge.
REQ-010 SHALL have port rd_sel  input  clog2(NUM_CHECKERS) (min 1)  checker index for count readback.
REQ-011 SHALL have port rd_count  output  CNT_WIDTH  failure count of checker rd_sel, combinational mux of registered counters.
REQ-012 SHALL have port first_valid  output  1  a failure has been captured since the last clear.
REQ-013 SHALL have port first_id  output  clog2(NUM_CHECKERS) (min 1)  index of the first failing checker.
REQ-014 SHALL have port first_time  output  TS_WIDTH  timestamp of the first failure.
REQ-015 SHALL have port irq  output  1  level interrupt, high while first_valid is high.

Function
REQ-016 SHALL define failure of checker i in a cycle as enable & (fire[3i] | fire[3i+1]); fire[3i+2] (cover) SHALL be ignored.
REQ-017 SHALL keep a free-running timestamp that increments by 1 each cycle enable is high, holds when enable is low, and saturates at all-ones (no wrap).
REQ-018 SHALL increment counter i by 1 on each failing cycle, saturating at 2^CNT_WIDTH-1.
REQ-019 SHALL make counter updates, first_* and irq visible one cycle after the sampling edge (latency 1).
REQ-020 SHALL, when first_valid is low and one or more checkers fail, set first_valid, load first_time with the current timestamp value (pre-increment), and load first_id with the lowest failing index.
REQ-021 SHALL hold first_id/first_time unchanged while first_valid is high, regardless of later failures.
REQ-022 SHALL drive irq as a registered copy equal to first_valid.
REQ-023 SHALL implement a clear FSM with states RUN, CLR, WAIT_DROP.
REQ-024 SHALL transition RUN -> CLR when clr_req is sampled high.
REQ-025 SHALL, in CLR, zero all counters, timestamp, first_valid, first_id, first_time, discard failures of that cycle, assert clr_ack, and go to WAIT_DROP.
REQ-026 SHALL keep clr_ack high in WAIT_DROP and return to RUN (clr_ack low) the cycle after clr_req is sampled low.
REQ-027 SHALL collect failures and advance the timestamp normally in WAIT_DROP and RUN.
REQ-028 SHALL treat rd_sel >= NUM_CHECKERS as returning rd_count = 0.

Reset
REQ-029 SHALL, on reset_n low, immediately force state RUN, all counters 0, timestamp 0, first_valid 0, first_id 0, first_time 0, irq 0, clr_ack 0.
REQ-030 SHALL abandon an in-progress clear handshake on reset; a clr_req still high after reset release SHALL start a new clear.

Verification
REQ-031 SHALL verify: enable=1, timestamp at 5, fire bits 0 and 7 (checkers 0 and 2) high one cycle -> next cycle first_valid=1, first_id=0, first_time=5, irq=1, counts {1,0,1,0}.
REQ-032 SHALL verify: CNT_WIDTH=8, checker 1 fire[4] (xcheck) high 300 cycles -> rd_sel=1 gives rd_count=255; cover-only fire[5] high produces no count.
REQ-033 SHALL verify: clr_req high with checker 3 failing in the same cycle as CLR -> all outputs zero, clr_ack=1, checker 3 not counted; clr_req low -> clr_ack low one cycle later.
REQ-034 SHALL verify: enable=0 with fires active for 10 cycles -> timestamp and counters unchanged, first_valid stays 0.
REQ-035 SHALL verify: TS_WIDTH=4, enable high 20 cycles then checker 0 fails -> first_time=15 (saturated).
REQ-036 SHALL verify: reset_n pulsed low mid-WAIT_DROP with counters nonzero -> outputs zero asynchronously, clr_ack=0, state RUN.
